// File: rtl/dmem_slave.sv
// Word-addressed data memory responder: byte-masked stores, registered loads,
// and a single in-order response after WAIT_CYCLES wait states.
module dmem_slave #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  output logic        o_ready,
  input  logic        i_is_store,
  input  logic [29:0] i_addr,
  input  logic [31:0] i_store_data,
  input  logic [3:0]  i_store_mask,
  output logic        o_rsp_valid,
  output logic [31:0] o_load_data,
  output logic        o_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            accept;
  logic            in_range;
  logic            wr_en;
  logic            rd_en;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]     pend_data;
  logic            pend_err_q;

  assign o_ready     = (state_q != BUSY);
  assign o_rsp_valid = (state_q == RESP);
  assign accept      = i_req && o_ready;
  // Upper address bits must be zero; no modulo aliasing onto the array.
  assign in_range    = ((i_addr >> ADDR_WIDTH) == 30'd0);
  assign idx         = i_addr[ADDR_WIDTH-1:0];
  assign wr_en       = accept && i_is_store && in_range;
  assign rd_en       = !i_is_store && in_range;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = RESP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      pend_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        pend_err_q <= !in_range;
      end
    end
  end

  // One byte-wide array per lane so each mask bit is a plain write enable.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem_lane [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge i_clk) begin
      if (i_rst_n && wr_en && i_store_mask[gi]) begin
        mem_lane[idx] <= i_store_data[8*gi +: 8];
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        rd_q <= 8'h00;
      end else if (accept) begin
        rd_q <= rd_en ? mem_lane[idx] : 8'h00;
      end
    end

    assign pend_data[8*gi +: 8] = rd_q;
  end

  // With wait states the latched result is only exposed on entering RESP.
  if (WAIT_CYCLES == 0) begin : g_nowait
    assign o_load_data = pend_data;
    assign o_err       = pend_err_q;
  end else begin : g_wait
    logic [31:0] out_data_q;
    logic        out_err_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        out_data_q <= 32'd0;
        out_err_q  <= 1'b0;
      end else if (state_q == BUSY && cnt_q == 4'd0) begin
        out_data_q <= pend_data;
        out_err_q  <= pend_err_q;
      end
    end

    assign o_load_data = out_data_q;
    assign o_err       = out_err_q;
  end

endmodule

// File: tb/tb_dmem_slave.sv
// Bench for dmem_slave: a zero-wait and a three-wait instance share one clock;
// expected responses are queued at issue time and popped when the DUT responds.
module tb_dmem_slave;

  typedef struct {
    bit          st;
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    logic [31:0] ed;
    bit          ee;
  } op_t;

  logic        clk;
  logic        rst0_n, req0, st0, rdy0, vld0, err0;
  logic [29:0] addr0;
  logic [31:0] wd0, ld0;
  logic [3:0]  mask0;
  logic        rst3_n, req3, st3, rdy3, vld3, err3;
  logic [29:0] addr3;
  logic [31:0] wd3, ld3;
  logic [3:0]  mask3;

  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] exp_q [$];

  dmem_slave #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_w0 (
    .i_clk(clk), .i_rst_n(rst0_n), .i_req(req0), .o_ready(rdy0),
    .i_is_store(st0), .i_addr(addr0), .i_store_data(wd0), .i_store_mask(mask0),
    .o_rsp_valid(vld0), .o_load_data(ld0), .o_err(err0)
  );

  dmem_slave #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) u_w3 (
    .i_clk(clk), .i_rst_n(rst3_n), .i_req(req3), .o_ready(rdy3),
    .i_is_store(st3), .i_addr(addr3), .i_store_data(wd3), .i_store_mask(mask3),
    .o_rsp_valid(vld3), .o_load_data(ld3), .o_err(err3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Drive one request on the zero-wait DUT for a single cycle (call at negedge).
  task automatic op0(input bit st, input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
    req0 = 1'b1; st0 = st; addr0 = a; wd0 = d; mask0 = m;
    @(negedge clk);
    req0 = 1'b0;
  endtask

  // Issue on the wait-state DUT; returns negedges from issue to the response.
  task automatic issue3(input bit st, input logic [29:0] a, input logic [31:0] d,
                        input logic [3:0] m, output int cyc);
    req3 = 1'b1; st3 = st; addr3 = a; wd3 = d; mask3 = m;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) req3 = 1'b0;
    end while (vld3 !== 1'b1 && cyc < 20);
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({rdy0, vld0, err0, ld0} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_bad++;
      $display("FAIL reset_w0: got rdy=%b vld=%b err=%b data=%h, required 1 0 0 00000000",
               rdy0, vld0, err0, ld0);
    end
    n_cmp++;
    if ({rdy3, vld3, err3, ld3} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_bad++;
      $display("FAIL reset_w3: got rdy=%b vld=%b err=%b data=%h, required 1 0 0 00000000",
               rdy3, vld3, err3, ld3);
    end
  endtask

  task automatic test_full_word;
    op_t ops [2];
    logic [32:0] e;
    ops = '{'{1'b1, 30'd5, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0},
            '{1'b0, 30'd5, 32'd0, 4'h0, 32'hDEADBEEF, 1'b0}};
    foreach (ops[i]) begin
      exp_q.push_back({ops[i].ee, ops[i].ed});
      op0(ops[i].st, ops[i].a, ops[i].d, ops[i].m);
      e = exp_q.pop_front();
      $display("full_word: st=%b addr=%h -> vld=%b data=%h err=%b", ops[i].st, ops[i].a, vld0, ld0, err0);
      n_cmp++;
      if (vld0 !== 1'b1 || ld0 !== e[31:0] || err0 !== e[32]) begin
        n_bad++;
        $display("FAIL full_word[%0d]: got vld=%b data=%h err=%b, required 1 %h %b",
                 i, vld0, ld0, err0, e[31:0], e[32]);
      end
    end
  endtask

  task automatic test_byte_mask;
    op_t ops [5];
    logic [32:0] e;
    ops = '{'{1'b1, 30'd7, 32'h11223344, 4'hF, 32'd0, 1'b0},
            '{1'b1, 30'd7, 32'h0000AA00, 4'b0010, 32'd0, 1'b0},
            '{1'b0, 30'd7, 32'd0, 4'h0, 32'h1122AA44, 1'b0},
            '{1'b1, 30'd7, 32'hFFFFFFFF, 4'b0000, 32'd0, 1'b0},
            '{1'b0, 30'd7, 32'd0, 4'h0, 32'h1122AA44, 1'b0}};
    foreach (ops[i]) begin
      exp_q.push_back({ops[i].ee, ops[i].ed});
      op0(ops[i].st, ops[i].a, ops[i].d, ops[i].m);
      e = exp_q.pop_front();
      $display("byte_mask: st=%b mask=%b -> vld=%b data=%h err=%b", ops[i].st, ops[i].m, vld0, ld0, err0);
      n_cmp++;
      if (vld0 !== 1'b1 || ld0 !== e[31:0] || err0 !== e[32]) begin
        n_bad++;
        $display("FAIL byte_mask[%0d]: got vld=%b data=%h err=%b, required 1 %h %b",
                 i, vld0, ld0, err0, e[31:0], e[32]);
      end
    end
  endtask

  task automatic test_out_of_range;
    op_t ops [5];
    logic [32:0] e;
    ops = '{'{1'b1, 30'h000, 32'h13572468, 4'hF, 32'd0, 1'b0},
            '{1'b0, 30'h400, 32'd0, 4'h0, 32'd0, 1'b1},
            '{1'b1, 30'h400, 32'hFFFFFFFF, 4'hF, 32'd0, 1'b1},
            '{1'b0, 30'h000, 32'd0, 4'h0, 32'h13572468, 1'b0},
            '{1'b0, 30'h3FFFFFFF, 32'd0, 4'h0, 32'd0, 1'b1}};
    foreach (ops[i]) begin
      exp_q.push_back({ops[i].ee, ops[i].ed});
      op0(ops[i].st, ops[i].a, ops[i].d, ops[i].m);
      e = exp_q.pop_front();
      $display("out_of_range: st=%b addr=%h -> vld=%b data=%h err=%b", ops[i].st, ops[i].a, vld0, ld0, err0);
      n_cmp++;
      if (vld0 !== 1'b1 || ld0 !== e[31:0] || err0 !== e[32]) begin
        n_bad++;
        $display("FAIL out_of_range[%0d]: got vld=%b data=%h err=%b, required 1 %h %b",
                 i, vld0, ld0, err0, e[31:0], e[32]);
      end
    end
  endtask

  task automatic test_back_to_back0;
    logic [32:0] e;
    exp_q.push_back({1'b0, 32'd0});
    exp_q.push_back({1'b0, 32'hCAFEF00D});
    req0 = 1'b1; st0 = 1'b1; addr0 = 30'd9; wd0 = 32'hCAFEF00D; mask0 = 4'hF;
    @(negedge clk);
    e = exp_q.pop_front();
    $display("b2b_w0 store: vld=%b rdy=%b data=%h", vld0, rdy0, ld0);
    n_cmp++;
    if (vld0 !== 1'b1 || rdy0 !== 1'b1 || ld0 !== e[31:0] || err0 !== e[32]) begin
      n_bad++;
      $display("FAIL b2b_w0_store: got vld=%b rdy=%b data=%h err=%b, required 1 1 %h %b",
               vld0, rdy0, ld0, err0, e[31:0], e[32]);
    end
    st0 = 1'b0;
    @(negedge clk);
    req0 = 1'b0;
    e = exp_q.pop_front();
    $display("b2b_w0 load: vld=%b rdy=%b data=%h", vld0, rdy0, ld0);
    n_cmp++;
    if (vld0 !== 1'b1 || rdy0 !== 1'b1 || ld0 !== e[31:0] || err0 !== e[32]) begin
      n_bad++;
      $display("FAIL b2b_w0_load: got vld=%b rdy=%b data=%h err=%b, required 1 1 %h %b",
               vld0, rdy0, ld0, err0, e[31:0], e[32]);
    end
    @(negedge clk);
    n_cmp++;
    if (vld0 !== 1'b0 || ld0 !== 32'hCAFEF00D) begin
      n_bad++;
      $display("FAIL b2b_w0_idle_hold: got vld=%b data=%h, required 0 cafef00d", vld0, ld0);
    end
  endtask

  task automatic test_wait_timing;
    int cyc;
    logic [32:0] e;
    exp_q.push_back({1'b0, 32'd0});
    issue3(1'b1, 30'd3, 32'h0BADF00D, 4'hF, cyc);
    e = exp_q.pop_front();
    $display("wait3 store: latency=%0d data=%h err=%b", cyc, ld3, err3);
    n_cmp++;
    if (cyc != 4 || ld3 !== e[31:0] || err3 !== e[32]) begin
      n_bad++;
      $display("FAIL wait3_store: got latency=%0d data=%h err=%b, required 4 %h %b",
               cyc, ld3, err3, e[31:0], e[32]);
    end
    // Issue the load in the store's response cycle, then watch each wait state.
    exp_q.push_back({1'b0, 32'h0BADF00D});
    req3 = 1'b1; st3 = 1'b0; addr3 = 30'd3;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      req3 = 1'b0;
      n_cmp++;
      if (rdy3 !== 1'b0 || vld3 !== 1'b0 || ld3 !== 32'd0) begin
        n_bad++;
        $display("FAIL wait3_busy[%0d]: got rdy=%b vld=%b data=%h, required 0 0 00000000",
                 k, rdy3, vld3, ld3);
      end
    end
    @(negedge clk);
    e = exp_q.pop_front();
    $display("wait3 load: vld=%b rdy=%b data=%h err=%b", vld3, rdy3, ld3, err3);
    n_cmp++;
    if (vld3 !== 1'b1 || rdy3 !== 1'b1 || ld3 !== e[31:0] || err3 !== e[32]) begin
      n_bad++;
      $display("FAIL wait3_load: got vld=%b rdy=%b data=%h err=%b, required 1 1 %h %b",
               vld3, rdy3, ld3, err3, e[31:0], e[32]);
    end
    @(negedge clk);
    n_cmp++;
    if (vld3 !== 1'b0 || ld3 !== 32'h0BADF00D) begin
      n_bad++;
      $display("FAIL wait3_after: got vld=%b data=%h, required 0 0badf00d", vld3, ld3);
    end
  endtask

  task automatic test_back_to_back3;
    op_t ops [5];
    logic [32:0] e;
    int cyc;
    ops = '{'{1'b1, 30'd3, 32'h12345678, 4'hF, 32'd0, 1'b0},
            '{1'b0, 30'd3, 32'd0, 4'h0, 32'h12345678, 1'b0},
            '{1'b1, 30'd3, 32'hFFFF0000, 4'b1100, 32'd0, 1'b0},
            '{1'b0, 30'd3, 32'd0, 4'h0, 32'hFFFF5678, 1'b0},
            '{1'b0, 30'h400, 32'd0, 4'h0, 32'd0, 1'b1}};
    foreach (ops[i]) begin
      exp_q.push_back({ops[i].ee, ops[i].ed});
      issue3(ops[i].st, ops[i].a, ops[i].d, ops[i].m, cyc);
      e = exp_q.pop_front();
      $display("b2b_w3: st=%b addr=%h -> latency=%0d data=%h err=%b", ops[i].st, ops[i].a, cyc, ld3, err3);
      n_cmp++;
      if (cyc != 4 || ld3 !== e[31:0] || err3 !== e[32]) begin
        n_bad++;
        $display("FAIL b2b_w3[%0d]: got latency=%0d data=%h err=%b, required 4 %h %b",
                 i, cyc, ld3, err3, e[31:0], e[32]);
      end
    end
  endtask

  task automatic test_reset_busy;
    int cyc;
    int seen;
    logic [32:0] e;
    exp_q.push_back({1'b0, 32'd0});
    issue3(1'b1, 30'd12, 32'hA5A5A5A5, 4'hF, cyc);
    e = exp_q.pop_front();
    n_cmp++;
    if (cyc != 4 || ld3 !== e[31:0]) begin
      n_bad++;
      $display("FAIL rst_pre_store: got latency=%0d data=%h, required 4 %h", cyc, ld3, e[31:0]);
    end
    // This load is abandoned by reset, so nothing is queued for it.
    req3 = 1'b1; st3 = 1'b0; addr3 = 30'd12;
    @(negedge clk);
    req3 = 1'b0;
    n_cmp++;
    if (rdy3 !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_busy_entry: got rdy=%b, required 0", rdy3);
    end
    rst3_n = 1'b0;
    #1;
    n_cmp++;
    if ({rdy3, vld3, err3, ld3} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_bad++;
      $display("FAIL rst_async: got rdy=%b vld=%b err=%b data=%h, required 1 0 0 00000000",
               rdy3, vld3, err3, ld3);
    end
    @(negedge clk);
    rst3_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (vld3 === 1'b1) seen++;
    end
    $display("rst_busy: responses after reset=%0d", seen);
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL rst_discard: got %0d responses, required 0", seen);
    end
    exp_q.push_back({1'b0, 32'hA5A5A5A5});
    issue3(1'b0, 30'd12, 32'd0, 4'h0, cyc);
    e = exp_q.pop_front();
    $display("rst_busy reload: latency=%0d data=%h err=%b", cyc, ld3, err3);
    n_cmp++;
    if (cyc != 4 || ld3 !== e[31:0] || err3 !== e[32]) begin
      n_bad++;
      $display("FAIL rst_retained: got latency=%0d data=%h err=%b, required 4 %h %b",
               cyc, ld3, err3, e[31:0], e[32]);
    end
  endtask

  initial begin
    rst0_n = 1'b0; rst3_n = 1'b0;
    req0 = 1'b0; st0 = 1'b0; addr0 = '0; wd0 = '0; mask0 = '0;
    req3 = 1'b0; st3 = 1'b0; addr3 = '0; wd3 = '0; mask3 = '0;
    repeat (3) @(negedge clk);
    rst0_n = 1'b1; rst3_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_full_word;
    test_byte_mask;
    test_back_to_back0;
    test_out_of_range;
    test_wait_timing;
    test_back_to_back3;
    test_reset_busy;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
